// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: four byte reads on a synchronous byte port,
// little-endian assembly, valid/ready response, halt/resume.
module imem_fetch_ctrl #(
  parameter int          MEM_BYTES = 10000,
  parameter int          ADDR_W    = 14,
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              halted,
  input  logic              resume,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_RESP,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [31:0] end_addr;
  logic        bad_addr;
  logic        accept;
  logic        hshake;
  logic        is_halt;

  // Range check stays 32-bit so wrapped addresses are rejected.
  assign end_addr = req_addr + 32'd3;
  assign bad_addr = (req_addr[1:0] != 2'b00) ||
                    (end_addr >= 32'(MEM_BYTES));
  assign accept   = req && (state_q == S_IDLE);
  assign hshake   = valid_q && rsp_ready;
  assign is_halt  = !err_q && (data_q[31:26] == HALT_OP);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      base_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      rd_q     <= 1'b0;
      maddr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      data_q   <= data_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      maddr_q  <= maddr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = bad_addr ? S_RESP : S_READ;
      end
      S_READ: begin
        if (k_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_RESP;
      S_RESP: begin
        if (hshake) state_d = is_halt ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    k_d      = k_q;
    base_d   = base_q;
    data_d   = data_q;
    err_d    = err_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    rd_d     = 1'b0;
    maddr_d  = maddr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d = req_addr[ADDR_W-1:0];
          k_d    = 2'd0;
          if (bad_addr) begin
            err_d   = 1'b1;
            data_d  = '0;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            rd_d    = 1'b1;
            maddr_d = req_addr[ADDR_W-1:0];
          end
        end
      end
      S_READ: begin
        // Byte for the previous strobe arrives while the next is issued.
        unique case (k_q)
          2'd1: data_d[7:0]   = mem_rdata;
          2'd2: data_d[15:8]  = mem_rdata;
          2'd3: data_d[23:16] = mem_rdata;
          default: ;
        endcase
        if (k_q != 2'd3) begin
          k_d     = k_q + 2'd1;
          rd_d    = 1'b1;
          maddr_d = base_q + ADDR_W'(k_q) + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        data_d[31:24] = mem_rdata;
        valid_d       = 1'b1;
      end
      S_RESP: begin
        if (hshake) begin
          valid_d = 1'b0;
          if (!err_q) cnt_d = cnt_q + 16'd1;
          if (is_halt) halted_d = 1'b1;
        end
      end
      S_HALT: begin
        if (resume) halted_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = valid_q;
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign halted      = halted_q;
  assign mem_rd      = rd_q;
  assign mem_addr    = maddr_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous byte memory model.
module tb_imem_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        halted;
  logic        resume;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] fetch_count;

  logic [7:0]  mem [16384];
  int          errs = 0;
  int          checks = 0;
  logic [15:0] exp_cnt;

  imem_fetch_ctrl dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .halted     (halted),
    .resume     (resume),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch_ok(input logic [31:0] addr,
                          input logic [31:0] exp,
                          input int stall);
    @(negedge CLK);
    chk("acc_ready", 32'(req_ready), 32'd1);
    req = 1'b1;
    req_addr = addr;
    @(negedge CLK);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_strobe", 32'(mem_rd), 32'd1);
      chk("rd_addr", 32'(mem_addr), (addr + 32'(i)) & 32'h3FFF);
      @(negedge CLK);
    end
    chk("drain_rd", 32'(mem_rd), 32'd0);
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_data", rsp_data, exp);
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (s == stall) rsp_ready = 1'b1;
      @(negedge CLK);
    end
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("cnt_after", 32'(fetch_count), 32'(exp_cnt));
    chk("valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic fetch_err(input logic [31:0] addr);
    @(negedge CLK);
    req = 1'b1;
    req_addr = addr;
    @(negedge CLK);
    req = 1'b0;
    chk("err_valid", 32'(rsp_valid), 32'd1);
    chk("err_flag", 32'(rsp_err), 32'd1);
    chk("err_data", rsp_data, 32'd0);
    chk("err_no_rd", 32'(mem_rd), 32'd0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("err_drop", 32'(rsp_valid), 32'd0);
    chk("err_ready", 32'(req_ready), 32'd1);
    chk("err_cnt", 32'(fetch_count), 32'(exp_cnt));
    chk("err_no_rd2", 32'(mem_rd), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}     = {8'h16, 8'h00, 8'h01, 8'h40};
    {mem[4], mem[5], mem[6], mem[7]}     = {8'h1B, 8'h00, 8'h02, 8'h04};
    {mem[8], mem[9], mem[10], mem[11]}   = {8'h00, 8'h18, 8'h22, 8'h00};
    {mem[44], mem[45], mem[46], mem[47]} = {8'h00, 8'h00, 8'h00, 8'hFC};
    {mem[9996], mem[9997], mem[9998], mem[9999]} =
      {8'h11, 8'h22, 8'h33, 8'h44};
    mem_rdata = 8'h00;
    Reset = 1'b1;
    req = 1'b0;
    req_addr = '0;
    rsp_ready = 1'b0;
    resume = 1'b0;
    exp_cnt = 16'd0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_cnt", 32'(fetch_count), 32'd0);

    fetch_ok(32'd0, 32'h40010016, 0);

    fetch_ok(32'd44, 32'hFC000000, 0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_ready", 32'(req_ready), 32'd0);
    req = 1'b1;
    req_addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("halt_no_rd", 32'(mem_rd), 32'd0);
      chk("halt_hold", 32'(halted), 32'd1);
    end
    req = 1'b0;
    resume = 1'b1;
    @(negedge CLK);
    resume = 1'b0;
    chk("resume_ready", 32'(req_ready), 32'd1);
    chk("resume_halt", 32'(halted), 32'd0);

    fetch_err(32'h0000_0002);
    fetch_err(32'd9997);
    fetch_err(32'hFFFF_FFFC);
    fetch_ok(32'd9996, 32'h44332211, 0);

    fetch_ok(32'd4, 32'h0402001B, 3);
    @(negedge CLK);
    chk("single_hs", 32'(fetch_count), 32'(exp_cnt));

    // Reset lands in cycle 3 of a fetch.
    @(negedge CLK);
    req = 1'b1;
    req_addr = 32'd4;
    @(negedge CLK);
    req = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    exp_cnt = 16'd0;
    chk("abort_rd", 32'(mem_rd), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_cnt", 32'(fetch_count), 32'd0);
    fetch_ok(32'd8, 32'h00221800, 0);

    @(negedge CLK);
    force dut.cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    chk("preset_cnt", 32'(fetch_count), 32'h0000FFFF);
    fetch_ok(32'd0, 32'h40010016, 0);
    chk("wrap_cnt", 32'(fetch_count), 32'd0);
    fetch_err(32'd10000);
    chk("wrap_err_cnt", 32'(fetch_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim ran past %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the CPU's byte-wide instruction memory. Accepts a 32-bit fetch address from the PC stage and issues four single-byte reads on a synchronous byte port. Assembles the bytes little-endian (byte at addr+0 lands in bits [7:0]) and returns the word over a valid/ready handshake. Rejects misaligned or out-of-range addresses, and stops fetching after delivering a halt instruction until the core resumes it.

## Interface
- MEM_BYTES, 10000: instruction memory size in bytes.
- ADDR_W, 14: width of the memory byte address.
- HALT_OP, 6'b111111: opcode (word[31:26]) that is treated as halt.

- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- req  in  1  fetch request.
- req_addr  in  32  byte address of the instruction; sampled on acceptance.
- req_ready  out  1  high only in IDLE.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  assembled instruction word; 0 on error.
- rsp_err  out  1  qualifies rsp_valid: address rejected.
- halted  out  1  halt instruction delivered; fetch suspended.
- resume  in  1  leaves HALT.
- mem_rd  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address for the read.
- mem_rdata  in  8  read data, valid exactly one cycle after mem_rd.
- fetch_count  out  16  count of error-free responses delivered; wraps at 0xFFFF -> 0.

## Operation
- States: IDLE, READ, DRAIN, RESP, HALT.
- IDLE:
  - req_ready=1.
  - req&req_ready accepts the request and latches req_addr.
  - If req_addr[1:0]!=0 or req_addr+3 >= MEM_BYTES, go to RESP with rsp_err=1 and rsp_data=0. No memory access is made.
  - Otherwise set byte index k=0 and go to READ.
- READ:
  - mem_rd=1, mem_addr=base+k, for k=0..3 on consecutive cycles.
  - Each mem_rdata arriving one cycle later is written into byte lane k-1.
  - After k=3, go to DRAIN.
- DRAIN: capture byte 3 into bits [31:24]; go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake, if !rsp_err, fetch_count increments.
  - Then go to HALT if !rsp_err and rsp_data[31:26]==HALT_OP, otherwise to IDLE.
- HALT:
  - halted=1, req_ready=0, no memory reads.
  - resume=1 goes to IDLE.
  - resume outside HALT is ignored.
- Address arithmetic is 32-bit. The range check uses the full 32-bit req_addr, so wrap-around addresses such as 0xFFFFFFFC are rejected. mem_addr is base+k truncated to ADDR_W.
- Outside READ, mem_rd=0 and mem_addr holds its last value.

## Timing
- Reset values: state IDLE, req_ready=1 (from the first cycle after reset), rsp_valid=0, rsp_data=0, rsp_err=0, halted=0, mem_rd=0, mem_addr=0, fetch_count=0.
- Reset mid-operation aborts the fetch immediately. No response is produced, and any pending halt or response is discarded.
- Valid fetch, request accepted at the end of cycle 0:
  - mem_rd high in cycles 1-4 (addresses base..base+3).
  - mem_rdata sampled at the end of cycles 2-5.
  - rsp_valid high from cycle 6.
- Error fetch: rsp_valid high from cycle 1.
- After a handshake at the end of cycle N, req_ready=1 in cycle N+1. Minimum valid-fetch period is 7 cycles.
- req_ready is never high while rsp_valid is high, so acceptance and response cannot coincide.
- All outputs are registered except req_ready, which is decoded from state.

## Test plan
- Memory bytes 0..3 = 16 00 01 40, fetch addr 0 -> mem_rd in cycles 1-4 with addr 0,1,2,3; rsp_valid in cycle 6; rsp_data=0x40010016, rsp_err=0, fetch_count=1.
- Bytes 44..47 = 00 00 00 FC, fetch 44 -> rsp_data=0xFC000000. After the handshake: halted=1, req_ready=0, and a req held high for 10 cycles produces no mem_rd. Pulse resume -> req_ready=1 next cycle, halted=0.
- Fetch 0x2 and fetch 9997 -> rsp_valid in cycle 1 with rsp_err=1, rsp_data=0, no mem_rd, fetch_count unchanged. Fetch 9996 -> normal 4-byte read.
- Fetch addr 4 (bytes 1B 00 02 04) with rsp_ready low for 3 cycles -> rsp_data=0x0402001B held stable across all 4 valid cycles; single handshake; fetch_count increments once.
- Reset asserted in cycle 3 of a fetch -> next cycle mem_rd=0, rsp_valid=0, req_ready=1. A following fetch of addr 8 returns 0x00221800.
- Preset fetch_count to 0xFFFF via 65535 fetches (or force) -> next good fetch gives 0x0000; an error fetch leaves it unchanged.
